// File: rtl/word_check_pkg.sv
// Shared types and constants for the word check scheduler.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents: word_t, MAGIC_DEFAULT, state_t (IDLE/CMP/RESP).
package word_check_pkg;

   typedef logic [31:0] word_t;

   localparam word_t MAGIC_DEFAULT = 32'h0000_ABCD;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage : word_check_pkg

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester found searching upward (wrapping) from last_id+1.
// Latency: purely combinational, zero cycles.
// Backpressure: none; en=0 forces an all-zero grant.
//
// Ports:
//   req     in  N           request vector
//   last_id in  clog2(N)    most recently served requester
//   en      in  1           grant enable
//   gnt     out N           one-hot grant (all zero when nothing granted)
//   gnt_id  out clog2(N)    index of the granted requester (0 when nothing granted)
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last_id,
   input  logic                 en,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id
);

   localparam int ID_W = $clog2(N);

   logic            found;
   int              sum;
   logic [ID_W-1:0] idx;

   always_comb begin
      gnt   = '0;
      gnt_id = '0;
      found = 1'b0;
      sum   = 0;
      idx   = '0;
      if (en) begin
         // Walk the N candidates in priority order; the first hit wins.
         for (int k = 1; k <= N; k++) begin
            sum = int'(last_id) + k;
            if (sum >= N) begin
               sum = sum - N;
            end
            idx = ID_W'(sum);
            if (!found && req[idx]) begin
               found       = 1'b1;
               gnt[idx]    = 1'b1;
               gnt_id      = idx;
            end
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/word_check_sched.sv
// Shares one 32-bit magic-word comparator among NUM_REQ requesters with round-robin arbitration.
// Latency: accept cycle, one compare cycle, result valid in the following cycle (2 cycles accept->rsp_valid).
// Backpressure: rsp_ready=0 holds the result and blocks all new accepts; req_ready is 0 outside IDLE.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_word     per-requester valid and packed 32-bit words (requester i at [32*i +: 32])
//   req_ready              one-hot accept, combinational from req_valid, state and last_id
//   cfg_we/cfg_magic       magic-word write port, honoured in any state
//   rsp_valid/rsp_ready    registered result handshake
//   rsp_id/rsp_match       registered result: requester id and word==magic flag
//   match_cnt              saturating count of matching results handed off
module word_check_sched
   import word_check_pkg::*;
#(
   parameter int    NUM_REQ   = 4,
   parameter word_t MAGIC_RST = MAGIC_DEFAULT,
   parameter int    CNT_W     = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*32-1:0]      req_word,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic                       cfg_we,
   input  logic [31:0]                cfg_magic,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic                       rsp_match,
   output logic [CNT_W-1:0]           match_cnt
);

   localparam int ID_W = $clog2(NUM_REQ);

   state_t            state_q;
   state_t            state_d;

   logic              arb_en;
   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]   gnt_id;
   logic              accept;
   logic              rsp_hs;
   word_t             pick_word;

   word_t             word_q;
   word_t             magic_q;
   logic [ID_W-1:0]   id_q;
   logic [ID_W-1:0]   last_id_q;
   logic              match_q;
   logic              rsp_valid_q;
   logic [CNT_W-1:0]  cnt_q;

   // Arbitration is only live in IDLE; gating with rst_n keeps req_ready low
   // while reset is held, even if requesters are already asserting valid.
   assign arb_en = rst_n && (state_q == IDLE);
   assign accept = |gnt;
   assign rsp_hs = rsp_valid_q && rsp_ready;

   rr_arbiter #(
      .N(NUM_REQ)
   ) u_arb (
      .req     (req_valid),
      .last_id (last_id_q),
      .en      (arb_en),
      .gnt     (gnt),
      .gnt_id  (gnt_id)
   );

   // AND-OR word mux keyed by the one-hot grant; req_word never reaches req_ready.
   always_comb begin
      pick_word = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            pick_word = pick_word | req_word[32*i +: 32];
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = CMP;
            end
         end
         CMP: begin
            state_d = RESP;
         end
         RESP: begin
            if (rsp_hs) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request capture, compare and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q      <= '0;
         id_q        <= '0;
         last_id_q   <= ID_W'(NUM_REQ - 1);
         match_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            word_q <= pick_word;
            id_q   <= gnt_id;
         end
         if (state_q == CMP) begin
            // magic_q here is the pre-edge value, so a same-edge cfg write
            // only takes effect for later compares.
            match_q     <= (word_q == magic_q);
            last_id_q   <= id_q;
            rsp_valid_q <= 1'b1;
         end else if (rsp_hs) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         magic_q <= MAGIC_RST;
      end else if (cfg_we) begin
         magic_q <= cfg_magic;
      end
   end

   // Count a match when its result is actually handed off, sticking at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (rsp_hs && match_q && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign req_ready = gnt;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = id_q;
   assign rsp_match = match_q;
   assign match_cnt = cnt_q;

endmodule : word_check_sched

// File: tb/tb_word_check_sched.sv
// Randomized self-checking bench for word_check_sched against a transaction-level reference model.
// Latency: n/a (bench).
// Backpressure: drives rsp_ready stalls of 0..10 cycles.
module tb_word_check_sched;
   import word_check_pkg::*;

   localparam int N      = 4;
   localparam int CW     = 4;
   localparam int CNTMAX = (1 << CW) - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N*32-1:0]   req_word;
   logic [N-1:0]      req_ready;
   logic              cfg_we;
   logic [31:0]       cfg_magic;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [1:0]        rsp_id;
   logic              rsp_match;
   logic [CW-1:0]     match_cnt;

   always #5 clk = ~clk;

   word_check_sched #(
      .NUM_REQ   (N),
      .MAGIC_RST (MAGIC_DEFAULT),
      .CNT_W     (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_word  (req_word),
      .req_ready (req_ready),
      .cfg_we    (cfg_we),
      .cfg_magic (cfg_magic),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_match (rsp_match),
      .match_cnt (match_cnt)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state: what each requester is offering, who was served
   // last, the programmed magic and the expected counter.
   bit [N-1:0] pend;
   word_t      words [N];
   int         mdl_last;
   word_t      mdl_magic;
   int         mdl_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int mdl_pick();
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (mdl_last + k) % N;
         if (pend[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [31:0] onehot(input int idx);
      logic [31:0] v;
      v = '0;
      if (idx >= 0) v[idx] = 1'b1;
      return v;
   endfunction

   function automatic int ready_idx(input logic [N-1:0] r);
      int cnt;
      int idx;
      cnt = 0;
      idx = -1;
      for (int i = 0; i < N; i++) begin
         if (r[i]) begin
            cnt++;
            idx = i;
         end
      end
      return (cnt == 1) ? idx : -1;
   endfunction

   function automatic word_t new_word();
      if ($urandom_range(0, 1) == 1) return mdl_magic;
      return word_t'($urandom);
   endfunction

   task automatic drive_reqs();
      req_valid = pend;
      for (int i = 0; i < N; i++) begin
         req_word[32*i +: 32] = words[i];
      end
   endtask

   task automatic mdl_reset();
      mdl_last  = N - 1;
      mdl_magic = MAGIC_DEFAULT;
      mdl_cnt   = 0;
      pend      = '0;
   endtask

   // Reset with requesters asserting valid to show req_ready stays low.
   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      rsp_ready = 1'b0;
      cfg_we    = 1'b0;
      req_valid = '1;
      #1;
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_id",    32'(rsp_id),    32'h0);
      check("rst_rsp_match", 32'(rsp_match), 32'h0);
      check("rst_match_cnt", 32'(match_cnt), 32'h0);
      mdl_reset();
      drive_reqs();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // One full transaction, entered and left at a negedge with the DUT in IDLE.
   // cfg_mode: 0 none, 1 magic write on the accept edge, 2 on the compare edge.
   task automatic run_txn(input int bp, input bit refill, input int cfg_mode,
                          input word_t cfg_val, output int got, output bit mseen);
      int    pick;
      word_t exp_w;
      bit    exp_match;
      rsp_ready = (bp == 0);
      drive_reqs();
      pick = mdl_pick();
      if (cfg_mode == 1) begin
         cfg_we    = 1'b1;
         cfg_magic = cfg_val;
      end
      #1;
      check("req_ready", 32'(req_ready), onehot(pick));
      got   = ready_idx(req_ready);
      mseen = 1'b0;
      if (pick < 0) begin
         cfg_we = 1'b0;
         return;
      end
      exp_w = words[pick];
      @(posedge clk);
      #1;
      if (cfg_mode == 1) begin
         cfg_we    = 1'b0;
         mdl_magic = cfg_val;
      end
      exp_match  = (exp_w == mdl_magic);
      pend[pick] = 1'b0;
      if (refill) begin
         pend[pick]  = 1'b1;
         words[pick] = new_word();
      end
      drive_reqs();
      if (cfg_mode == 2) begin
         cfg_we    = 1'b1;
         cfg_magic = cfg_val;
      end
      @(negedge clk);
      check("cmp_rsp_valid", 32'(rsp_valid), 32'h0);
      check("cmp_req_ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      #1;
      if (cfg_mode == 2) begin
         cfg_we    = 1'b0;
         mdl_magic = cfg_val;
      end
      mdl_last = pick;
      @(negedge clk);
      check("rsp_valid", 32'(rsp_valid), 32'h1);
      check("rsp_id",    32'(rsp_id),    32'(pick));
      check("rsp_match", 32'(rsp_match), 32'(exp_match));
      check("resp_req_ready", 32'(req_ready), 32'h0);
      mseen = rsp_match;
      for (int k = 0; k < bp; k++) begin
         @(negedge clk);
         check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
         check("bp_rsp_id",    32'(rsp_id),    32'(pick));
         check("bp_rsp_match", 32'(rsp_match), 32'(exp_match));
         check("bp_req_ready", 32'(req_ready), 32'h0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      if (exp_match && mdl_cnt < CNTMAX) mdl_cnt++;
      check("hs_rsp_valid", 32'(rsp_valid), 32'h0);
      check("match_cnt",    32'(match_cnt), 32'(mdl_cnt));
   endtask

   task automatic drain();
      int got;
      bit m;
      while (pend != '0) begin
         run_txn(0, 1'b0, 0, '0, got, m);
      end
   endtask

   initial begin
      int got;
      bit m;
      int tmp;
      rst_n     = 1'b0;
      req_valid = '0;
      req_word  = '0;
      cfg_we    = 1'b0;
      cfg_magic = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < N; i++) words[i] = '0;
      mdl_reset();

      // Single request straight after reset.
      do_reset();
      pend[2]  = 1'b1;
      words[2] = 32'h0000_ABCD;
      run_txn(0, 1'b0, 0, '0, got, m);
      check("single_grant", 32'(got), 32'd2);
      check("single_match", 32'(m), 32'h1);
      check("single_cnt", 32'(match_cnt), 32'd1);

      // Idle with nothing requested: no grant, no response.
      pend = '0;
      drive_reqs();
      #1;
      check("idle_req_ready", 32'(req_ready), 32'h0);
      @(negedge clk);
      check("idle_rsp_valid", 32'(rsp_valid), 32'h0);

      // All requesters held valid: strict 0,1,2,3,0 rotation from reset.
      do_reset();
      for (int i = 0; i < N; i++) begin
         pend[i]  = 1'b1;
         words[i] = new_word();
      end
      for (int i = 0; i < 5; i++) begin
         run_txn(0, 1'b1, 0, '0, got, m);
         check("rr_order", 32'(got), 32'(i % N));
      end

      // Long backpressure with other requesters still waiting.
      run_txn(10, 1'b0, 0, '0, got, m);
      drain();

      // Magic reprogram: write on the accept edge applies to that compare.
      pend[1]  = 1'b1;
      words[1] = 32'h0000_ABCD;
      run_txn(0, 1'b0, 1, 32'h1234_5678, got, m);
      check("magic_old_word", 32'(m), 32'h0);
      pend[3]  = 1'b1;
      words[3] = 32'h1234_5678;
      run_txn(0, 1'b0, 0, '0, got, m);
      check("magic_new_word", 32'(m), 32'h1);
      // Write on the compare edge must not affect that compare.
      pend[0]  = 1'b1;
      words[0] = 32'h1234_5678;
      run_txn(0, 1'b0, 2, 32'hDEAD_BEEF, got, m);
      check("magic_cmp_edge_old", 32'(m), 32'h1);
      pend[2]  = 1'b1;
      words[2] = 32'hDEAD_BEEF;
      run_txn(0, 1'b0, 0, '0, got, m);
      check("magic_cmp_edge_new", 32'(m), 32'h1);

      // Counter saturation: 17 matches saturate a 4-bit counter.
      for (int i = 0; i < 17; i++) begin
         tmp        = $urandom_range(0, N - 1);
         pend[tmp]  = 1'b1;
         words[tmp] = mdl_magic;
         run_txn(0, 1'b0, 0, '0, got, m);
      end
      check("cnt_saturated", 32'(match_cnt), 32'hF);

      // Randomized mix: arrivals, stalls and occasional reprogramming.
      for (int i = 0; i < 40; i++) begin
         int    mode;
         word_t nv;
         for (int r = 0; r < N; r++) begin
            if (!pend[r] && $urandom_range(0, 2) != 0) begin
               pend[r]  = 1'b1;
               words[r] = new_word();
            end
         end
         if (pend == '0) begin
            pend[0]  = 1'b1;
            words[0] = new_word();
         end
         mode = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
         nv   = ($urandom_range(0, 1) == 1) ? word_t'($urandom) : words[$urandom_range(0, N - 1)];
         run_txn($urandom_range(0, 3), 1'b0, mode, nv, got, m);
      end
      drain();

      // Reset while a result is waiting in RESP.
      pend[1]  = 1'b1;
      words[1] = mdl_magic;
      rsp_ready = 1'b0;
      drive_reqs();
      @(posedge clk);
      #1;
      pend = '0;
      drive_reqs();
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_rsp_valid", 32'(rsp_valid), 32'h1);
      rst_n = 1'b0;
      #1;
      check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("midrst_match_cnt", 32'(match_cnt), 32'h0);
      check("midrst_rsp_id",    32'(rsp_id),    32'h0);
      check("midrst_rsp_match", 32'(rsp_match), 32'h0);
      mdl_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pend[0]  = 1'b1;
      words[0] = word_t'($urandom);
      pend[3]  = 1'b1;
      words[3] = MAGIC_DEFAULT;
      run_txn(0, 1'b0, 0, '0, got, m);
      check("post_rst_prio", 32'(got), 32'd0);
      run_txn(0, 1'b0, 0, '0, got, m);
      check("post_rst_next", 32'(got), 32'd3);
      check("post_rst_default_magic", 32'(m), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_word_check_sched
